// File: rtl/deser_align_ctrl_pkg.sv
// Shared types and constants for the deserializer word-alignment controller.
// Also holds small helpers for tap arithmetic and state classification.
package ti_roic_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_CHECK   = 3'd2,
    ST_SLIP    = 3'd3,
    ST_TAP     = 3'd4,
    ST_CONFIRM = 3'd5,
    ST_LOCKED  = 3'd6,
    ST_FAIL    = 3'd7
  } align_state_e;

  localparam logic [7:0] FRAME_PATTERN_DEF = 8'hF0;
  localparam int         TAP_W             = 5;
  localparam int         TIMER_W           = 16;

  // One bit wider than the tap so TAP_MAX + TAP_STEP cannot wrap.
  function automatic logic [TAP_W:0] tap_add(input logic [TAP_W-1:0] tap,
                                             input logic [TAP_W:0]   step);
    return {1'b0, tap} + step;
  endfunction

  function automatic logic state_is_busy(input align_state_e st);
    case (st)
      ST_IDLE, ST_LOCKED, ST_FAIL: return 1'b0;
      default:                     return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/deser_align_ctrl_if.sv
// Controller-side bundle: frame word and start request in, slip/tap controls and status out.
// slave is the controller, master is the surrounding deserializer logic.
interface deser_align_ctrl_if #(parameter int WORD_W = 8);
  import ti_roic_align_pkg::*;

  localparam int SLIP_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic              align_start;
  logic [WORD_W-1:0] frame_word;
  logic              bitslip;
  logic              dly_ld;
  logic [TAP_W-1:0]  dly_tap;
  logic [SLIP_W-1:0] slip_cnt;
  logic              aligned;
  logic              align_err;
  logic              busy;

  modport master (
    output align_start, frame_word,
    input  bitslip, dly_ld, dly_tap, slip_cnt, aligned, align_err, busy
  );

  modport slave (
    input  align_start, frame_word,
    output bitslip, dly_ld, dly_tap, slip_cnt, aligned, align_err, busy
  );

endinterface

// File: rtl/deser_align_ctrl_timer.sv
// Loadable down-counter shared by settle/gap waits and the confirm/loss counters.
// done is high while the count sits at zero; load wins over decrement.
module align_wait_timer
  import ti_roic_align_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk_div,
  input  logic         clk_reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] cnt_r;

  // Counter register: reload on strobe, otherwise count down to zero and hold.
  always_ff @(posedge clk_div) begin
    if (clk_reset) begin
      cnt_r <= {W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != {W{1'b0}})) begin
      cnt_r <= cnt_r - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign done = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/deser_align_ctrl.sv
// Word-alignment FSM: bitslips and IDELAY tap steps until the frame word matches,
// then confirms and supervises lock, realigning after a run of mismatches.
module deser_align_ctrl
  import ti_roic_align_pkg::*;
#(
  parameter int   WORD_W        = 8,
  parameter logic [WORD_W-1:0] FRAME_PATTERN = WORD_W'(FRAME_PATTERN_DEF),
  parameter int   SETTLE_CYCLES = 16,
  parameter int   SLIP_GAP      = 4,
  parameter int   LOCK_CONFIRM  = 8,
  parameter int   LOSS_THRESH   = 4,
  parameter int   TAP_MAX       = 31,
  parameter int   TAP_STEP      = 1,
  parameter bit   AUTO_START    = 1'b1
) (
  input logic               clk_div,
  input logic               clk_reset,
  deser_align_ctrl_if.slave bus
);

  localparam int SLIP_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [SLIP_W-1:0]  SLIP_LAST  = SLIP_W'(WORD_W - 1);
  localparam logic [SLIP_W-1:0]  SLIP_ONE   = SLIP_W'(1);
  // Timer holds (cycles - 1); the CHECK sample already counts as the first match.
  localparam logic [TIMER_W-1:0] SETTLE_LD  = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LD     = TIMER_W'(SLIP_GAP - 1);
  localparam logic [TIMER_W-1:0] CONFIRM_LD = TIMER_W'((LOCK_CONFIRM > 1) ? (LOCK_CONFIRM - 2) : 0);
  localparam logic [TIMER_W-1:0] LOSS_LD    = TIMER_W'(LOSS_THRESH - 1);
  localparam logic [TAP_W:0]     TAP_MAX_W  = (TAP_W+1)'(TAP_MAX);
  localparam logic [TAP_W:0]     TAP_STEP_W = (TAP_W+1)'(TAP_STEP);

  align_state_e       state_r;
  align_state_e       state_nx_s;
  align_state_e       miss_nx_s;
  logic               start_pend_r;
  logic               bitslip_r;
  logic               dly_ld_r;
  logic [TAP_W-1:0]   dly_tap_r;
  logic [SLIP_W-1:0]  slip_cnt_r;
  logic               aligned_r;
  logic               align_err_r;
  logic               busy_r;

  logic               match_s;
  logic               restart_s;
  logic               loss_s;
  logic               tap_ld_s;
  logic [TAP_W:0]     tap_next_s;
  logic               tmr_ld_s;
  logic               tmr_dec_s;
  logic [TIMER_W-1:0] tmr_val_s;
  logic               tmr_done_s;

  assign match_s    = (bus.frame_word == FRAME_PATTERN);
  assign restart_s  = bus.align_start && (state_r != ST_IDLE);
  assign miss_nx_s  = (slip_cnt_r < SLIP_LAST) ? ST_SLIP : ST_TAP;
  assign tap_next_s = tap_add(dly_tap_r, TAP_STEP_W);
  assign tap_ld_s   = (state_nx_s == ST_TAP) && (tap_next_s <= TAP_MAX_W);

  align_wait_timer #(.W(TIMER_W)) u_timer (
    .clk_div   (clk_div),
    .clk_reset (clk_reset),
    .load      (tmr_ld_s),
    .load_val  (tmr_val_s),
    .dec       (tmr_dec_s),
    .done      (tmr_done_s)
  );

  // Next-state and timer control; a restart request overrides every transition.
  always_comb begin
    state_nx_s = state_r;
    tmr_ld_s   = 1'b0;
    tmr_dec_s  = 1'b0;
    tmr_val_s  = {TIMER_W{1'b0}};
    loss_s     = 1'b0;
    if (restart_s) begin
      state_nx_s = ST_WAIT;
      tmr_ld_s   = 1'b1;
      tmr_val_s  = SETTLE_LD;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.align_start || start_pend_r) begin
            state_nx_s = ST_WAIT;
            tmr_ld_s   = 1'b1;
            tmr_val_s  = SETTLE_LD;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_WAIT: begin
          tmr_dec_s  = 1'b1;
          state_nx_s = tmr_done_s ? ST_CHECK : ST_WAIT;
        end
        ST_CHECK: begin
          if (!match_s) begin
            state_nx_s = miss_nx_s;
          end else if (LOCK_CONFIRM == 1) begin
            state_nx_s = ST_LOCKED;
            tmr_ld_s   = 1'b1;
            tmr_val_s  = LOSS_LD;
          end else begin
            state_nx_s = ST_CONFIRM;
            tmr_ld_s   = 1'b1;
            tmr_val_s  = CONFIRM_LD;
          end
        end
        ST_SLIP: begin
          state_nx_s = ST_WAIT;
          tmr_ld_s   = 1'b1;
          tmr_val_s  = GAP_LD;
        end
        ST_TAP: begin
          // dly_ld is high here exactly when the step stayed within TAP_MAX.
          if (dly_ld_r) begin
            state_nx_s = ST_WAIT;
            tmr_ld_s   = 1'b1;
            tmr_val_s  = SETTLE_LD;
          end else begin
            state_nx_s = ST_FAIL;
          end
        end
        ST_CONFIRM: begin
          if (!match_s) begin
            state_nx_s = miss_nx_s;
          end else if (tmr_done_s) begin
            state_nx_s = ST_LOCKED;
            tmr_ld_s   = 1'b1;
            tmr_val_s  = LOSS_LD;
          end else begin
            tmr_dec_s  = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (match_s) begin
            tmr_ld_s   = 1'b1;
            tmr_val_s  = LOSS_LD;
          end else if (tmr_done_s) begin
            loss_s     = 1'b1;
            state_nx_s = ST_WAIT;
            tmr_ld_s   = 1'b1;
            tmr_val_s  = SETTLE_LD;
          end else begin
            tmr_dec_s  = 1'b1;
          end
        end
        ST_FAIL: begin
          state_nx_s = ST_FAIL;
        end
        default: begin
          state_nx_s = ST_IDLE;
        end
      endcase
    end
  end

  // State and registered outputs; pulses are high for the whole SLIP/TAP or restart cycle.
  always_ff @(posedge clk_div) begin
    if (clk_reset) begin
      state_r      <= ST_IDLE;
      start_pend_r <= AUTO_START;
      bitslip_r    <= 1'b0;
      dly_ld_r     <= 1'b0;
      dly_tap_r    <= {TAP_W{1'b0}};
      slip_cnt_r   <= {SLIP_W{1'b0}};
      aligned_r    <= 1'b0;
      align_err_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      start_pend_r <= 1'b0;
      bitslip_r    <= (state_nx_s == ST_SLIP);
      dly_ld_r     <= restart_s || tap_ld_s;
      aligned_r    <= (state_r == ST_LOCKED) && (state_nx_s == ST_LOCKED);
      align_err_r  <= (state_nx_s == ST_FAIL);
      busy_r       <= state_is_busy(state_nx_s);
      if (restart_s) begin
        dly_tap_r  <= {TAP_W{1'b0}};
        slip_cnt_r <= {SLIP_W{1'b0}};
      end else if (tap_ld_s) begin
        dly_tap_r  <= tap_next_s[TAP_W-1:0];
        slip_cnt_r <= {SLIP_W{1'b0}};
      end else if (state_nx_s == ST_SLIP) begin
        dly_tap_r  <= dly_tap_r;
        slip_cnt_r <= slip_cnt_r + SLIP_ONE;
      end else if (loss_s) begin
        dly_tap_r  <= dly_tap_r;
        slip_cnt_r <= {SLIP_W{1'b0}};
      end else begin
        dly_tap_r  <= dly_tap_r;
        slip_cnt_r <= slip_cnt_r;
      end
    end
  end

  assign bus.bitslip   = bitslip_r;
  assign bus.dly_ld    = dly_ld_r;
  assign bus.dly_tap   = dly_tap_r;
  assign bus.slip_cnt  = slip_cnt_r;
  assign bus.aligned   = aligned_r;
  assign bus.align_err = align_err_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_deser_align_ctrl.sv
// Directed bench for deser_align_ctrl with a behavioural lane model in the loop.
// Expected dly_tap values are queued when a scenario starts and popped on each dly_ld pulse.
module tb_deser_align_ctrl;
  import ti_roic_align_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  deser_align_ctrl_if #(.WORD_W(8)) bus_if();

  deser_align_ctrl dut (
    .clk_div   (clk),
    .clk_reset (rst),
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  int n_cmp   = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int exp_q[$];
  int mode    = 0;
  int rot     = 0;
  int tap_m   = 0;
  int slips_m = 0;
  bit force_bad = 1'b0;
  int bs_cnt  = 0;
  int ld_cnt  = 0;
  int last_bs = -1000;
  int min_gap = 1000;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Lane model: 0 aligned, 1 rotated by rot, 2 good only at tap 2 with no slips, 3 never good.
  function automatic logic [7:0] lane_word();
    logic [7:0] p;
    p = 8'hF0;
    if (force_bad) return 8'h00;
    case (mode)
      0: return p;
      1: begin
        for (int i = 0; i < rot; i++) p = {p[6:0], p[7]};
        return p;
      end
      2: return ((tap_m == 2) && (slips_m == 0)) ? p : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  task automatic tick();
    int gap;
    @(posedge clk);
    #1;
    cyc++;
    chk("bs_ld_excl", int'(bus_if.bitslip & bus_if.dly_ld), 0);
    if (bus_if.bitslip) begin
      bs_cnt++;
      gap = cyc - last_bs;
      if (gap < min_gap) min_gap = gap;
      last_bs = cyc;
      slips_m++;
      rot = (rot + 7) % 8;
    end
    if (bus_if.dly_ld) begin
      ld_cnt++;
      tap_m   = int'(bus_if.dly_tap);
      slips_m = 0;
      if (exp_q.size() > 0) chk("dly_ld_tap", int'(bus_if.dly_tap), exp_q.pop_front());
      else                  chk("dly_ld_unexpected", int'(bus_if.dly_ld), 0);
    end
    bus_if.frame_word = lane_word();
  endtask

  task automatic clr_stats();
    bs_cnt  = 0;
    ld_cnt  = 0;
    last_bs = -1000;
    min_gap = 1000;
  endtask

  task automatic restart();
    exp_q.push_back(0);
    bus_if.frame_word  = lane_word();
    bus_if.align_start = 1'b1;
    tick();
    bus_if.align_start = 1'b0;
  endtask

  task automatic wait_aligned(input int budget);
    int n = 0;
    while (bus_if.aligned !== 1'b1 && n < budget) begin tick(); n++; end
    chk("aligned_timeout", int'(bus_if.aligned), 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bitslip"},  int'(bus_if.bitslip),   0);
    chk({tag, "_dly_ld"},   int'(bus_if.dly_ld),    0);
    chk({tag, "_dly_tap"},  int'(bus_if.dly_tap),   0);
    chk({tag, "_slip_cnt"}, int'(bus_if.slip_cnt),  0);
    chk({tag, "_aligned"},  int'(bus_if.aligned),   0);
    chk({tag, "_err"},      int'(bus_if.align_err), 0);
    chk({tag, "_busy"},     int'(bus_if.busy),      0);
  endtask

  initial begin
    int n;
    bus_if.align_start = 1'b0;
    bus_if.frame_word  = 8'hF0;

    // Reset state, then auto-start lock with the pattern present.
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (i == 0) chk("auto_start_busy", int'(bus_if.busy), 1);
    end
    chk("lock_latency_early", int'(bus_if.aligned), 0);
    tick();
    chk("lock_latency", int'(bus_if.aligned), 1);
    chk("locked_busy", int'(bus_if.busy), 0);
    chk("auto_no_bitslip", bs_cnt, 0);
    chk("auto_no_dly_ld", ld_cnt, 0);

    // Word rotated by 3: three bitslips at tap 0.
    clr_stats();
    mode = 1; rot = 3;
    restart();
    wait_aligned(400);
    chk("rot_bitslips", bs_cnt, 3);
    chk("rot_min_gap_ok", int'(min_gap >= 6), 1);
    chk("rot_slip_cnt", int'(bus_if.slip_cnt), 3);
    chk("rot_dly_tap", int'(bus_if.dly_tap), 0);

    // Good only at tap 2: seven slips at taps 0 and 1, then tap loads 1 and 2.
    clr_stats();
    mode = 2;
    exp_q.push_back(0);
    restart();
    exp_q.delete();
    exp_q.push_back(1);
    exp_q.push_back(2);
    wait_aligned(800);
    chk("tap2_bitslips", bs_cnt, 14);
    chk("tap2_min_gap_ok", int'(min_gap >= 6), 1);
    chk("tap2_dly_tap", int'(bus_if.dly_tap), 2);
    chk("tap2_slip_cnt", int'(bus_if.slip_cnt), 0);
    chk("tap2_sb_empty", exp_q.size(), 0);

    // Lock supervision: three mismatches hold lock, the fourth drops it.
    clr_stats();
    force_bad = 1'b1; bus_if.frame_word = lane_word();
    for (int i = 0; i < 3; i++) begin tick(); chk("hold_aligned", int'(bus_if.aligned), 1); end
    force_bad = 1'b0; bus_if.frame_word = lane_word();
    tick();
    chk("hold_after_match", int'(bus_if.aligned), 1);
    force_bad = 1'b1; bus_if.frame_word = lane_word();
    for (int i = 0; i < 3; i++) begin tick(); chk("loss_pre_aligned", int'(bus_if.aligned), 1); end
    tick();
    chk("loss_aligned", int'(bus_if.aligned), 0);
    chk("loss_busy", int'(bus_if.busy), 1);
    chk("loss_dly_tap", int'(bus_if.dly_tap), 2);
    force_bad = 1'b0; bus_if.frame_word = lane_word();
    wait_aligned(100);
    chk("relock_bitslips", bs_cnt, 0);
    chk("relock_dly_tap", int'(bus_if.dly_tap), 2);

    // Never matches: every tap up to 31 is tried, then FAIL.
    clr_stats();
    mode = 3;
    restart();
    for (int t = 1; t <= 31; t++) exp_q.push_back(t);
    n = 0;
    while (bus_if.align_err !== 1'b1 && n < 5000) begin tick(); n++; end
    chk("fail_align_err", int'(bus_if.align_err), 1);
    chk("fail_aligned", int'(bus_if.aligned), 0);
    chk("fail_busy", int'(bus_if.busy), 0);
    chk("fail_dly_tap", int'(bus_if.dly_tap), 31);
    chk("fail_bitslips", bs_cnt, 224);
    chk("fail_sb_empty", exp_q.size(), 0);
    tick(); tick();
    chk("fail_sticky", int'(bus_if.align_err), 1);
    mode = 0;
    restart();
    chk("fail_restart_err", int'(bus_if.align_err), 0);
    chk("fail_restart_tap", int'(bus_if.dly_tap), 0);
    chk("fail_restart_busy", int'(bus_if.busy), 1);
    chk("fail_restart_sb", exp_q.size(), 0);
    wait_aligned(100);

    // Reset in the middle of a bitslip; align_start during reset is ignored.
    clr_stats();
    mode = 3;
    restart();
    n = 0;
    while (bus_if.bitslip !== 1'b1 && n < 100) begin tick(); n++; end
    chk("pre_reset_bitslip", int'(bus_if.bitslip), 1);
    rst = 1'b1;
    tick();
    chk_all_zero("rst_slip");
    bus_if.align_start = 1'b1;
    tick();
    chk_all_zero("rst_start");
    rst = 1'b0;
    bus_if.align_start = 1'b0;
    mode = 0; bus_if.frame_word = lane_word();
    tick();
    chk("post_rst_bitslip", int'(bus_if.bitslip), 0);
    chk("post_rst_dly_ld", int'(bus_if.dly_ld), 0);
    chk("post_rst_busy", int'(bus_if.busy), 1);
    wait_aligned(100);
    chk("post_rst_dly_tap", int'(bus_if.dly_tap), 0);
    chk("final_sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
